l1d_lsu_responder: RTL

L1D_LSU_RESPONDER -- requirements
Module: l1d_lsu_responder

---
 rtl/l1d_lsu_responder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/l1d_lsu_responder.sv
// L1D responder for LSU load/store requests.
// Queues requests in a small FIFO, services them in order against a
// resettable word array after a fixed access latency, and returns one
// single-cycle response pulse per accepted request.
//
// Ports:
//   clk_in          sole clock, rising edge
//   rst_in          asynchronous active-high reset
//   lsu_valid_in    request valid from LSU
//   lsu_mem_op_in   request op (mem_op_e)
//   lsu_addr_in     byte address; word index is addr[log2(MEM_WORDS)+2:3]
//   lsu_data_in     store data
//   lsu_ready_out   FIFO has room (from registered count)
//   lsu_valid_out   one-cycle response pulse
//   lsu_data_out    response data, held between pulses

package l1d_types_pkg;
    typedef enum logic [1:0] {
        MEM_LOAD  = 2'd0,
        MEM_STORE = 2'd1,
        MEM_AMO   = 2'd2,
        MEM_FENCE = 2'd3
    } mem_op_e;
endpackage

module l1d_lsu_responder
    import l1d_types_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LATENCY    = 3,
    parameter int MEM_WORDS  = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        lsu_valid_in,
    input  mem_op_e     lsu_mem_op_in,
    input  logic [63:0] lsu_addr_in,
    input  logic [63:0] lsu_data_in,
    output logic        lsu_ready_out,
    output logic        lsu_valid_out,
    output logic [63:0] lsu_data_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef struct packed {
        mem_op_e          op;
        logic [IDX_W-1:0] idx;
        logic [63:0]      data;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_e;

    req_t             r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    state_e           r_state;
    req_t             r_work;
    logic [LAT_W-1:0] r_lat;
    logic             r_valid;
    logic [63:0]      r_data;
    logic [63:0]      r_mem [MEM_WORDS];

    logic             w_push;
    logic             w_pop;
    req_t             w_req;
    logic             w_unused_addr;

    // Only the word-index bits matter; the rest alias.
    assign w_unused_addr = ^{lsu_addr_in[63:IDX_W+3], lsu_addr_in[2:0]};

    assign w_req = '{
        op:   lsu_mem_op_in,
        idx:  lsu_addr_in[IDX_W+2:3],
        data: lsu_data_in
    };

    // Ready comes from the registered count only, so a pop on the
    // same edge never lets a full FIFO accept.
    assign lsu_ready_out = (r_count < CNT_W'(FIFO_DEPTH));
    assign w_push        = lsu_valid_in && lsu_ready_out;
    assign w_pop         = ((r_state == S_IDLE) || (r_state == S_RESP))
                           && (r_count != '0);

    assign lsu_valid_out = r_valid;
    assign lsu_data_out  = r_data;

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_req;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_lat   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_pop) begin
                        r_work  <= r_fifo[r_rd_ptr];
                        r_lat   <= LAT_W'(LATENCY - 1);
                        r_state <= S_BUSY;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (r_lat != '0) begin
                        r_lat <= r_lat - LAT_W'(1);
                    end else begin
                        case (r_work.op)
                            MEM_LOAD: begin
                                r_data <= r_mem[r_work.idx];
                            end
                            MEM_STORE: begin
                                r_mem[r_work.idx] <= r_work.data;
                                r_data            <= r_work.data;
                            end
                            default: begin
                                r_data <= '0;
                            end
                        endcase
                        r_valid <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
